// File: rtl/instr_pkg.sv
// instr_pkg: class codes, MIPS opcodes and queue depth shared by the encoder and control decoder
package instr_pkg;
    localparam logic [2:0] CLS_RTYPE = 3'd0;
    localparam logic [2:0] CLS_LW    = 3'd1;
    localparam logic [2:0] CLS_SW    = 3'd2;
    localparam logic [2:0] CLS_BEQ   = 3'd3;
    localparam logic [2:0] CLS_ADDI  = 3'd4;
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam int QUEUE_DEPTH = 4;
endpackage

// File: rtl/instr_encoder_fifo.sv
// instr_fifo: in-order synchronous queue with flush; flush wins over same-cycle push/pop
module instr_fifo
    import instr_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    logic [W-1:0]  mem_d [QUEUE_DEPTH];
    logic [W-1:0]  mem_q [QUEUE_DEPTH];
    logic [PW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [PW:0]   cnt_d, cnt_q;
    logic          do_push, do_pop;

    assign full  = cnt_q == (PW+1)'(QUEUE_DEPTH);
    assign empty = cnt_q == '0;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = flush ? '0 : do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = flush ? '0 : do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = flush ? '0 : cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        if (do_push && !flush) mem_d[wr_ptr_q] = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS instruction requests into a 4-deep queue and issues them downstream
module instr_encoder
    import instr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_class,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [5:0]  req_funct,
    input  logic [15:0] req_imm,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [5:0]  out_opcode,
    output logic        err_unsup,
    output logic [15:0] issue_count
);
    logic [5:0]  opcode;
    logic [31:0] enc_instr;
    logic        supported, accept, push, pop, full, empty;
    logic        err_unsup_d, err_unsup_q;
    logic [15:0] issue_count_d, issue_count_q;

    instr_fifo #(.W(32)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata (enc_instr),
        .pop   (pop),
        .rdata (out_instr),
        .full  (full),
        .empty (empty)
    );

    assign req_ready   = !full;
    assign out_valid   = !empty;
    assign out_opcode  = out_instr[31:26];
    assign err_unsup   = err_unsup_q;
    assign issue_count = issue_count_q;

    always_comb begin
        opcode = req_class == CLS_LW   ? OP_LW   :
                 req_class == CLS_SW   ? OP_SW   :
                 req_class == CLS_BEQ  ? OP_BEQ  :
                 req_class == CLS_ADDI ? OP_ADDI : OP_RTYPE;
        enc_instr = req_class == CLS_RTYPE ? {opcode, req_rs, req_rt, req_rd, 5'b0, req_funct}
                                           : {opcode, req_rs, req_rt, req_imm};
        supported     = req_class <= CLS_ADDI;
        accept        = req_valid && req_ready && !flush;
        push          = accept && supported;
        pop           = out_valid && out_ready;
        err_unsup_d   = accept && !supported;
        issue_count_d = issue_count_q + ((pop && !flush) ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_unsup_q   <= 1'b0;
            issue_count_q <= '0;
        end else begin
            err_unsup_q   <= err_unsup_d;
            issue_count_q <= issue_count_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and random checks against a queue-based reference model
module tb_instr_encoder;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready;
    logic [2:0]  req_class = 0;
    logic [4:0]  req_rs = 0, req_rt = 0, req_rd = 0;
    logic [5:0]  req_funct = 0;
    logic [15:0] req_imm = 0;
    logic        flush = 0, out_valid, out_ready = 0;
    logic [31:0] out_instr;
    logic [5:0]  out_opcode;
    logic        err_unsup;
    logic [15:0] issue_count;

    int checks = 0, failures = 0;
    logic [31:0] model_q[$];
    logic        err_exp = 0;
    logic [15:0] cnt_exp = 0;
    logic [15:0] base;
    int          opc_tab[5] = '{0, 35, 43, 4, 8};

    instr_encoder dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_funct(req_funct), .req_imm(req_imm), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_opcode(out_opcode),
        .err_unsup(err_unsup), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] encode(int cls, int rs, int rt, int rd, int funct, int imm);
        int w;
        w = opc_tab[cls] * 67108864 + rs * 2097152 + rt * 65536;
        w += (cls == 0) ? rd * 2048 + funct : imm;
        return 32'(w);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        chk("req_ready", 32'(req_ready), 32'(model_q.size() < 4));
        chk("err_unsup", 32'(err_unsup), 32'(err_exp));
        chk("issue_count", 32'(issue_count), 32'(cnt_exp));
        if (model_q.size() > 0) begin
            chk("out_instr", out_instr, model_q[0]);
            chk("out_opcode", 32'(out_opcode), 32'(model_q[0][31:26]));
        end
    endtask

    // Check current outputs, advance the model by one clock, then let the DUT take the same edge.
    task automatic step();
        bit acc, pop;
        check_outputs();
        acc = req_valid && model_q.size() < 4;
        pop = model_q.size() > 0 && out_ready;
        if (flush) begin
            model_q.delete();
            err_exp = 0;
        end else begin
            if (pop) begin
                void'(model_q.pop_front());
                cnt_exp++;
            end
            if (acc && req_class <= 4)
                model_q.push_back(encode(req_class, req_rs, req_rt, req_rd, req_funct, req_imm));
            err_exp = acc && req_class > 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, int cls, int rs, int rt, int rd, int funct, int imm);
        req_valid = v;
        req_class = 3'(cls);
        req_rs    = 5'(rs);
        req_rt    = 5'(rt);
        req_rd    = 5'(rd);
        req_funct = 6'(funct);
        req_imm   = 16'(imm);
    endtask

    initial begin
        #2;
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_instr", out_instr, 0);
        chk("reset_count", 32'(issue_count), 0);
        @(posedge clk);
        #1;
        rst = 0;
        chk("ready_after_reset", 32'(req_ready), 1);

        drive(1, 0, 1, 2, 3, 32, 16'hABCD);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rtype_instr", out_instr, 32'h00221820);
        chk("rtype_opcode", 32'(out_opcode), 0);
        out_ready = 1;
        step();
        drive(1, 1, 29, 8, 17, 5, 16'h0004);
        step();
        drive(1, 3, 4, 5, 0, 0, 16'hFFFE);
        chk("lw_instr", out_instr, 32'h8FA80004);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("beq_instr", out_instr, 32'h1085FFFE);
        step();

        out_ready = 0;
        base = cnt_exp;
        for (int i = 0; i < 5; i++) begin
            drive(1, 4, i, i + 1, 0, 0, 100 + i);
            step();
            if (i == 3) chk("full_ready_low", 32'(req_ready), 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("addi_order", out_instr, encode(4, i, i + 1, 0, 0, 100 + i));
            step();
        end
        chk("addi_issue", 32'(issue_count), 32'(base + 16'd4));
        chk("addi_ready", 32'(req_ready), 1);
        chk("addi_drained", 32'(out_valid), 0);

        drive(1, 6, 3, 3, 3, 3, 3);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("unsup_pulse", 32'(err_unsup), 1);
        chk("unsup_empty", 32'(out_valid), 0);
        step();
        chk("unsup_pulse_end", 32'(err_unsup), 0);

        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 2, i, 7, 0, 0, i * 8);
            step();
        end
        base = cnt_exp;
        out_ready = 1;
        flush = 1;
        drive(1, 4, 1, 1, 0, 0, 1);
        step();
        flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_ready", 32'(req_ready), 1);
        chk("flush_count", 32'(issue_count), 32'(base));

        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            drive(1, 4, 2, 3, 0, 0, i);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1;
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_opcode", 32'(out_opcode), 0);
        chk("rst_err", 32'(err_unsup), 0);
        chk("rst_count", 32'(issue_count), 0);
        model_q.delete();
        err_exp = 0;
        cnt_exp = 0;
        @(posedge clk);
        #1;
        rst = 0;
        check_outputs();
        out_ready = 1;
        drive(1, 4, 0, 9, 0, 0, 7);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_addi", out_instr, 32'h20090007);
        step();

        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
                  $urandom_range(0, 65535));
            out_ready = 1'($urandom_range(0, 2) != 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        out_ready = 1;
        for (int i = 0; i < 5; i++) step();
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous reset, active-high.
REQ-004 req_valid  in  1  an encode request is present.
REQ-005 req_ready  out  1  the block can accept a request this cycle.
REQ-006 req_class  in  3  instruction class: 0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI; 5-7 unsupported.
REQ-007 req_rs, req_rt, req_rd  in  5 each  register fields.
REQ-008 req_funct  in  6  R-type function field.
REQ-009 req_imm  in  16  I-type immediate field.
REQ-010 flush  in  1  synchronous clear of all queued instructions.
REQ-011 out_valid  out  1  out_instr and out_opcode are valid.
REQ-012 out_ready  in  1  the consumer accepts the head instruction.
REQ-013 out_instr  out  32  encoded MIPS instruction word.
REQ-014 out_opcode  out  6  equal to out_instr[31:26], for the downstream decoder.
REQ-015 err_unsup  out  1  one-cycle pulse reporting a rejected unsupported class.
REQ-016 issue_count  out  16  count of instructions handed off downstream.

Function
REQ-017 Opcodes SHALL be: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000.
REQ-018 RTYPE encoding SHALL be {opcode, rs, rt, rd, 5'b0 shamt, funct}. The req_imm input is ignored.
REQ-019 LW/SW/BEQ/ADDI encoding SHALL be {opcode, rs, rt, imm}. The req_rd and req_funct inputs are ignored.
REQ-020 Supported requests SHALL be pushed into a 4-entry in-order queue. A request is accepted when req_valid and req_ready are both high.
REQ-021 req_ready SHALL be high exactly when the queue holds fewer than 4 entries.
- req_ready has no combinational dependence on out_ready.
- A full queue with a pop in the same cycle still shows req_ready low.
REQ-022 Latency SHALL be 1 cycle: an accepted request into an empty queue gives out_valid high on the next cycle. There is no same-cycle bypass.
REQ-023 out_valid SHALL be high exactly when the queue is non-empty. out_instr and out_opcode come from the queue head.
REQ-024 While out_valid is high and out_ready is low, out_instr and out_opcode SHALL hold stable.
REQ-025 A handshake is out_valid and out_ready both high. On a handshake the head entry SHALL be popped and issue_count SHALL increment, wrapping from 16'hFFFF to 0.
REQ-026 A push and a pop in the same cycle SHALL leave the occupancy unchanged and keep order.
REQ-027 Unsupported classes (5-7) SHALL be accepted while req_ready is high but not enqueued. err_unsup SHALL go high for exactly the next cycle.
REQ-028 flush SHALL empty the queue on the next edge.
- flush has priority over a same-cycle push and pop.
- A request offered with flush is dropped.
- A handshake offered with flush does not increment issue_count.
- issue_count is not cleared by flush.
REQ-029 Queue read and write pointers SHALL wrap modulo 4. Occupancy is held in a 3-bit count (range 0-4).

Reset
REQ-030 While rst is high, all state SHALL be cleared asynchronously:
- out_valid = 0, out_instr = 0, out_opcode = 0, err_unsup = 0, issue_count = 0.
- Pointers and occupancy = 0, so req_ready = 1 once reset releases.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries with no handshake on release.

Structure
REQ-032 A shared package instr_pkg SHALL hold:
- the class codes;
- the five opcode constants, shared with the control decoder;
- the queue depth constant (4).
REQ-033 The queue SHALL be a sub-module instr_fifo (synchronous FIFO with flush). Encoding logic stays in instr_encoder.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- RTYPE with rs=1, rt=2, rd=3, funct=0x20 -> out_instr=0x00221820 and out_opcode=000000, 1 cycle after acceptance.
- LW with rs=29, rt=8, imm=0x0004 -> 0x8FA80004. BEQ with rs=4, rt=5, imm=0xFFFE -> 0x1085FFFE.
- Five back-to-back ADDIs with out_ready=0 -> req_ready low after the 4th. Then out_ready=1 -> four words out in order, issue_count=4, req_ready high again.
- req_class=6 -> nothing enqueued, out_valid stays 0, err_unsup high for exactly one cycle.
- Queue holding 3 entries, flush together with push and pop -> next cycle out_valid=0, req_ready=1, issue_count unchanged.
- rst asserted mid-stream with 2 entries queued -> all outputs 0 immediately; after release, an ADDI with rs=0, rt=9, imm=7 -> 0x20090007.
